mem_stage: RTL and testbench

Memory-access pipeline stage plus the MEM/WB pipeline register of the 5-stage MIPS core. Takes the EX/MEM bundle, performs byte/halfword/word loads and stores against an internal little-endian word-organised data memory, and registers the result bundle. The registered outputs drive the write-back mux: ALUResult, ReadData, PC and the 2-bit MemToReg select, plus register-file write control. Stall and flush inputs come from the hazard unit.

---
 rtl/mem_stage_if.sv | 37 +++
 rtl/mem_stage.sv | 126 ++++++++++++
 tb/tb_mem_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM-to-WB bundle of the memory stage: hazard controls, EX/MEM inputs and the
// registered MEM/WB outputs that feed the write-back mux.
interface mem_stage_if;
    logic        Stall;
    logic        Flush;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic        RegWrite_In;
    logic [1:0]  MemToReg_In;
    logic [4:0]  WriteReg_In;
    logic [31:0] ALUResult_In;
    logic [31:0] WriteData_In;
    logic [31:0] PC_In;
    logic        RegWrite_Out;
    logic [1:0]  MemToReg_Out;
    logic [4:0]  WriteReg_Out;
    logic [31:0] ALUResult_Out;
    logic [31:0] ReadData_Out;
    logic [31:0] PC_Out;
    logic        Fault_Out;

    modport master (
        output Stall, Flush, MemRead, MemWrite, MemSize, MemSigned,
               RegWrite_In, MemToReg_In, WriteReg_In, ALUResult_In, WriteData_In, PC_In,
        input  RegWrite_Out, MemToReg_Out, WriteReg_Out, ALUResult_Out,
               ReadData_Out, PC_Out, Fault_Out
    );

    modport slave (
        input  Stall, Flush, MemRead, MemWrite, MemSize, MemSigned,
               RegWrite_In, MemToReg_In, WriteReg_In, ALUResult_In, WriteData_In, PC_In,
        output RegWrite_Out, MemToReg_Out, WriteReg_Out, ALUResult_Out,
               ReadData_Out, PC_Out, Fault_Out
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: little-endian byte/halfword/word loads and stores against
// an internal word-organised data memory, followed by the MEM/WB pipeline register.
module mem_stage #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic         Clock,
    input  logic         Reset,
    mem_stage_if.slave   bus
);

    logic [31:0]           mem_r [0:(2**ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] word_idx_s;
    logic [1:0]            offset_s;
    logic                  misaligned_s;
    logic                  commit_s;
    logic [31:0]           rd_word_s;
    logic [7:0]            rd_byte_s;
    logic [15:0]           rd_half_s;
    logic [31:0]           load_data_s;
    logic [3:0]            byte_en_s;
    logic [31:0]           wr_data_s;
    logic                  unused_s;

    assign word_idx_s = bus.ALUResult_In[ADDR_WIDTH+1:2];
    assign offset_s   = bus.ALUResult_In[1:0];
    assign unused_s   = ^{bus.ALUResult_In[31:ADDR_WIDTH+2]};

    // Alignment check: bytes never fault, halfwords need an even address, words a 4-byte one.
    always_comb begin
        misaligned_s = 1'b0;
        case (bus.MemSize)
            2'b01:   misaligned_s = offset_s[0];
            2'b10:   misaligned_s = 1'b0;
            default: misaligned_s = (offset_s != 2'b00);
        endcase
        if (!(bus.MemRead || bus.MemWrite)) begin
            misaligned_s = 1'b0;
        end else begin
            misaligned_s = misaligned_s;
        end
    end

    // Reset is part of the commit term so no edge writes while the pipeline is held in reset.
    assign commit_s = bus.MemWrite & ~misaligned_s & ~bus.Stall & ~bus.Flush & Reset;

    assign rd_word_s = mem_r[word_idx_s];
    assign rd_byte_s = rd_word_s[{offset_s, 3'b000} +: 8];
    assign rd_half_s = offset_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

    // Lane select and sign/zero extension of the pre-store word contents.
    always_comb begin
        load_data_s = 32'h0000_0000;
        if (bus.MemRead) begin
            case (bus.MemSize)
                2'b01:   load_data_s = bus.MemSigned ? {{16{rd_half_s[15]}}, rd_half_s}
                                                     : {16'h0000, rd_half_s};
                2'b10:   load_data_s = bus.MemSigned ? {{24{rd_byte_s[7]}}, rd_byte_s}
                                                     : {24'h00_0000, rd_byte_s};
                default: load_data_s = rd_word_s;
            endcase
        end else begin
            load_data_s = 32'h0000_0000;
        end
    end

    // Store lane replication and byte enables; only enabled lanes reach the array.
    always_comb begin
        byte_en_s = 4'b0000;
        wr_data_s = bus.WriteData_In;
        case (bus.MemSize)
            2'b01: begin
                wr_data_s = {2{bus.WriteData_In[15:0]}};
                byte_en_s = offset_s[1] ? 4'b1100 : 4'b0011;
            end
            2'b10: begin
                wr_data_s = {4{bus.WriteData_In[7:0]}};
                byte_en_s = 4'b0001 << offset_s;
            end
            default: begin
                wr_data_s = bus.WriteData_In;
                byte_en_s = 4'b1111;
            end
        endcase
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge Clock) begin
        if (commit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // MEM/WB register: flush inserts a bubble, stall holds, otherwise load the new bundle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bus.RegWrite_Out  <= 1'b0;
            bus.MemToReg_Out  <= 2'b00;
            bus.WriteReg_Out  <= 5'd0;
            bus.ALUResult_Out <= 32'h0000_0000;
            bus.ReadData_Out  <= 32'h0000_0000;
            bus.PC_Out        <= 32'h0000_0000;
            bus.Fault_Out     <= 1'b0;
        end else if (bus.Flush) begin
            bus.RegWrite_Out  <= 1'b0;
            bus.MemToReg_Out  <= 2'b00;
            bus.WriteReg_Out  <= 5'd0;
            bus.ALUResult_Out <= 32'h0000_0000;
            bus.ReadData_Out  <= 32'h0000_0000;
            bus.PC_Out        <= 32'h0000_0000;
            bus.Fault_Out     <= 1'b0;
        end else if (!bus.Stall) begin
            bus.RegWrite_Out  <= bus.RegWrite_In & ~misaligned_s;
            bus.MemToReg_Out  <= bus.MemToReg_In;
            bus.WriteReg_Out  <= bus.WriteReg_In;
            bus.ALUResult_Out <= bus.ALUResult_In;
            bus.ReadData_Out  <= load_data_s;
            bus.PC_Out        <= bus.PC_In;
            bus.Fault_Out     <= misaligned_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a byte-addressed reference model predicts every MEM/WB
// output; literal checks pin the model on the key load/store cases.
module tb_mem_stage;

    logic Clock;
    logic Reset;
    mem_stage_if bus ();

    mem_stage #(.ADDR_WIDTH(10)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int passed = 0;
    int total  = 0;

    logic [7:0] mbytes [0:4095];

    logic        exp_rw, pend_rw;
    logic [1:0]  exp_m2r, pend_m2r;
    logic [4:0]  exp_wr, pend_wr;
    logic [31:0] exp_alu, pend_alu, exp_rd, pend_rd, exp_pc, pend_pc;
    logic        exp_flt, pend_flt, exp_rd_ok, pend_rd_ok;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        else passed++;
    endtask

    always @(negedge Clock) begin
        if (chk_en) begin
            check("RegWrite_Out",  {31'd0, bus.RegWrite_Out}, {31'd0, exp_rw});
            check("MemToReg_Out",  {30'd0, bus.MemToReg_Out}, {30'd0, exp_m2r});
            check("WriteReg_Out",  {27'd0, bus.WriteReg_Out}, {27'd0, exp_wr});
            check("ALUResult_Out", bus.ALUResult_Out, exp_alu);
            check("PC_Out",        bus.PC_Out, exp_pc);
            check("Fault_Out",     {31'd0, bus.Fault_Out}, {31'd0, exp_flt});
            if (exp_rd_ok) check("ReadData_Out", bus.ReadData_Out, exp_rd);
        end
    end

    // Reference model: what the MEM/WB register must hold after the coming edge.
    task automatic model_step();
        int a, n;
        logic mis, commit;
        logic [31:0] v;
        a = int'(bus.ALUResult_In & 32'h0000_0FFF);
        n = (bus.MemSize == 2'b01) ? 2 : (bus.MemSize == 2'b10) ? 1 : 4;
        mis = (bus.MemRead || bus.MemWrite) && (a % n != 0);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | ({24'd0, mbytes[(a + i) % 4096]} << (8 * i));
        if (bus.MemSigned && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        if (!bus.MemRead) v = 32'd0;
        commit = bus.MemWrite && !mis && !bus.Stall && !bus.Flush && Reset;
        if (commit)
            for (int i = 0; i < n; i++) mbytes[a + i] = bus.WriteData_In[8*i +: 8];
        {pend_rw, pend_m2r, pend_wr, pend_alu, pend_rd, pend_pc, pend_flt, pend_rd_ok} =
            {exp_rw, exp_m2r, exp_wr, exp_alu, exp_rd, exp_pc, exp_flt, exp_rd_ok};
        if (!Reset || bus.Flush) begin
            {pend_rw, pend_m2r, pend_wr, pend_alu, pend_rd, pend_pc, pend_flt} = '0;
            pend_rd_ok = 1'b1;
        end else if (!bus.Stall) begin
            pend_rw    = bus.RegWrite_In && !mis;
            pend_m2r   = bus.MemToReg_In;
            pend_wr    = bus.WriteReg_In;
            pend_alu   = bus.ALUResult_In;
            pend_pc    = bus.PC_In;
            pend_flt   = mis;
            pend_rd    = v;
            pend_rd_ok = !mis;
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge Clock);
        #1;
        {exp_rw, exp_m2r, exp_wr, exp_alu, exp_rd, exp_pc, exp_flt, exp_rd_ok} =
            {pend_rw, pend_m2r, pend_wr, pend_alu, pend_rd, pend_pc, pend_flt, pend_rd_ok};
    endtask

    int pc = 32'h0040_0000;

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                      input logic [4:0] wreg, input logic [31:0] addr, input logic [31:0] wdata);
        bus.MemRead      = rd;
        bus.MemWrite     = wr;
        bus.MemSize      = sz;
        bus.MemSigned    = sgn;
        bus.RegWrite_In  = rd | (wreg != 5'd0);
        bus.MemToReg_In  = rd ? 2'd1 : 2'd0;
        bus.WriteReg_In  = wreg;
        bus.ALUResult_In = addr;
        bus.WriteData_In = wdata;
        bus.PC_In        = pc;
        pc = pc + 4;
        cyc();
    endtask

    task automatic lw(input logic [31:0] addr);
        op(1'b1, 1'b0, 2'b00, 1'b0, 5'd8, addr, 32'd0);
    endtask

    task automatic sw(input logic [31:0] addr, input logic [31:0] d);
        op(1'b0, 1'b1, 2'b00, 1'b0, 5'd0, addr, d);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mbytes[i] = 8'hxx;
        Reset = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        {exp_rw, exp_m2r, exp_wr, exp_alu, exp_rd, exp_pc, exp_flt} = '0;
        exp_rd_ok = 1'b1;
        op(1'b0, 1'b0, 2'b00, 1'b0, 5'd3, 32'h1234, 32'd0);
        chk_en = 1'b1;
        check("reset ALUResult", bus.ALUResult_Out, 32'h0);
        check("reset PC", bus.PC_Out, 32'h0);
        Reset = 1'b1;

        sw(32'h40, 32'hDEADBEEF);
        lw(32'h40);
        check("LW data", bus.ReadData_Out, 32'hDEADBEEF);
        check("LW MemToReg", {30'd0, bus.MemToReg_Out}, 32'd1);
        check("LW RegWrite", {31'd0, bus.RegWrite_Out}, 32'd1);

        sw(32'h40, 32'h11223344);
        op(1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'h41, 32'hAAAAAA80);
        lw(32'h40);
        check("SB merge", bus.ReadData_Out, 32'h11228044);
        op(1'b1, 1'b0, 2'b10, 1'b1, 5'd9, 32'h41, 32'd0);
        check("LB", bus.ReadData_Out, 32'hFFFFFF80);
        op(1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 32'h41, 32'd0);
        check("LBU", bus.ReadData_Out, 32'h00000080);
        op(1'b1, 1'b0, 2'b01, 1'b1, 5'd9, 32'h42, 32'd0);
        check("LH hi", bus.ReadData_Out, 32'h00001122);
        op(1'b1, 1'b0, 2'b01, 1'b1, 5'd9, 32'h40, 32'd0);
        check("LH lo", bus.ReadData_Out, 32'hFFFF8044);

        op(1'b0, 1'b1, 2'b00, 1'b0, 5'd4, 32'h42, 32'hCAFEF00D);
        check("SW mis fault", {31'd0, bus.Fault_Out}, 32'd1);
        check("SW mis regwr", {31'd0, bus.RegWrite_Out}, 32'd0);
        lw(32'h40);
        check("SW mis no write", bus.ReadData_Out, 32'h11228044);
        op(1'b1, 1'b0, 2'b01, 1'b0, 5'd9, 32'h43, 32'd0);
        check("LH mis fault", {31'd0, bus.Fault_Out}, 32'd1);
        check("LH mis regwr", {31'd0, bus.RegWrite_Out}, 32'd0);

        lw(32'h40);
        bus.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'h40, 32'h0000005A);
            check("stall hold", bus.ReadData_Out, 32'h11228044);
        end
        bus.Stall = 1'b0;
        op(1'b0, 1'b1, 2'b10, 1'b0, 5'd0, 32'h40, 32'h0000005A);
        lw(32'h40);
        check("stalled SB", bus.ReadData_Out, 32'h1122805A);

        bus.Stall = 1'b1;
        bus.Flush = 1'b1;
        op(1'b0, 1'b1, 2'b00, 1'b0, 5'd7, 32'h40, 32'hFFFFFFFF);
        check("flush bubble", {31'd0, bus.RegWrite_Out}, 32'd0);
        bus.Stall = 1'b0;
        lw(32'h40);
        bus.Flush = 1'b0;
        lw(32'h40);
        check("flush no write", bus.ReadData_Out, 32'h1122805A);

        sw(32'h1000, 32'h12345678);
        lw(32'h0);
        check("wrap", bus.ReadData_Out, 32'h12345678);
        op(1'b1, 1'b1, 2'b00, 1'b0, 5'd2, 32'h0, 32'h0BADF00D);
        check("rd+wr old", bus.ReadData_Out, 32'h12345678);
        lw(32'h0);
        check("rd+wr new", bus.ReadData_Out, 32'h0BADF00D);

        bus.MemRead = 1'b0;
        bus.MemWrite = 1'b1;
        bus.MemSize = 2'b00;
        bus.ALUResult_In = 32'h0;
        bus.WriteData_In = 32'h77777777;
        #2;
        Reset = 1'b0;
        {exp_rw, exp_m2r, exp_wr, exp_alu, exp_rd, exp_pc, exp_flt} = '0;
        exp_rd_ok = 1'b1;
        #1;
        check("async rst data", bus.ReadData_Out, 32'h0);
        check("async rst regwr", {31'd0, bus.RegWrite_Out}, 32'd0);
        cyc();
        Reset = 1'b1;
        lw(32'h0);
        check("post-reset mem", bus.ReadData_Out, 32'h0BADF00D);
        op(1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 32'h0, 32'h0);
        @(negedge Clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
